xloader_chip: RTL and testbench

// Boot-loader top: after reset it reads LOAD_BYTES bytes from the external SPI NOR flash
// (single-bit READ 0x03 on CS0) and streams each byte out of the UART, 8N1.
// It also mirrors received UART bytes onto pads[7:1]. pads[0] is a boot-enable strap.
// The reboot_key input restarts the load. Sits at chip level, between the flash and the host UART.

---
 rtl/xloader_chip.sv | 228 ++++++++++++++++++++++
 tb/tb_xloader_chip.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xloader_chip.sv
// Boot loader: streams LOAD_BYTES bytes read from SPI NOR flash out of the UART (8N1),
// and mirrors bytes received on the UART onto pads[7:1].
module xloader_chip #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUDRATE   = 25000000,
  parameter logic [23:0] BOOT_ADDR  = 24'h0,
  parameter int unsigned LOAD_BYTES = 16,
  parameter int unsigned SCK_DIV    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reboot_key,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       qspi_sck,
  inout  wire        qspi_dq0,
  inout  wire        qspi_dq1,
  inout  wire        qspi_dq2,
  inout  wire        qspi_dq3,
  output logic       qspi_cs0,
  output logic       qspi_cs1,
  output logic       qspi_cs2,
  output logic       qspi_cs3,
  inout  wire  [7:0] pads
);

  localparam int unsigned BAUD_DIV = CLK_HZ / BAUDRATE;
  localparam int unsigned SCK_HALF = SCK_DIV / 2;
  localparam int unsigned RX_FIRST = BAUD_DIV / 2 - 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCmd  = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StSend = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        sck_q, sck_d;
  logic        cs_q, cs_d;
  logic        tx_q, tx_d;
  logic        hold_q, hold_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic [8:0]  frame_q, frame_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [15:0] count_q, count_d;

  logic [2:0]  key_sync_q, rx_sync_q;
  logic        reboot_fall, rx_bit, rx_start;

  logic        rx_busy_q;
  logic [15:0] rx_cnt_q;
  logic [3:0]  rx_idx_q;
  logic [7:0]  rx_sh_q;
  logic [6:0]  pads_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_sync_q <= 3'b111;
      rx_sync_q  <= 3'b111;
    end else begin
      key_sync_q <= {key_sync_q[1:0], reboot_key};
      rx_sync_q  <= {rx_sync_q[1:0], uart_rx};
    end
  end

  assign reboot_fall = key_sync_q[2] & ~key_sync_q[1];
  assign rx_bit      = rx_sync_q[1];
  assign rx_start    = rx_sync_q[2] & ~rx_sync_q[1];

  always_comb begin
    state_d   = state_q;
    sck_d     = sck_q;
    cs_d      = cs_q;
    tx_d      = tx_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    data_d    = data_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    count_d   = count_q;
    case (state_q)
      StIdle: begin
        // hold_q stretches cs0 high for a second clock after a reboot
        if (hold_q) begin
          hold_d = 1'b0;
        end else if (pads[0]) begin
          cs_d      = 1'b0;
          shift_d   = {8'h03, BOOT_ADDR};
          bit_cnt_d = '0;
          div_cnt_d = '0;
          state_d   = StCmd;
        end else begin
          state_d = StDone;
        end
      end
      StCmd, StData: begin
        div_cnt_d = div_cnt_q + 16'd1;
        if (div_cnt_q == 16'(SCK_HALF - 1)) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (!sck_q) begin
            if (state_q == StData) data_d = {data_q[6:0], qspi_dq1};
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (state_q == StCmd) begin
              shift_d = {shift_q[30:0], 1'b0};
              if (bit_cnt_q == 6'd31) begin
                bit_cnt_d = '0;
                state_d   = StData;
              end
            end else if (bit_cnt_q == 6'd7) begin
              bit_cnt_d = '0;
              tx_d      = 1'b0;
              frame_d   = {1'b1, data_q};
              state_d   = StSend;
            end
          end
        end
      end
      StSend: begin
        div_cnt_d = div_cnt_q + 16'd1;
        if (div_cnt_q == 16'(BAUD_DIV - 1)) begin
          div_cnt_d = '0;
          if (bit_cnt_q == 6'd9) begin
            bit_cnt_d = '0;
            count_d   = count_q + 16'd1;
            if (count_q + 16'd1 == 16'(LOAD_BYTES)) begin
              cs_d    = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StData;
            end
          end else begin
            tx_d      = frame_q[0];
            frame_d   = {1'b1, frame_q[8:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
      end
      StDone: begin
        sck_d = 1'b0;
        cs_d  = 1'b1;
        tx_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (reboot_fall) begin
      state_d = StIdle;
      hold_d  = 1'b1;
      tx_d    = 1'b1;
      cs_d    = 1'b1;
      sck_d   = 1'b0;
      shift_d = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      tx_q      <= 1'b1;
      hold_q    <= 1'b0;
      shift_q   <= '0;
      data_q    <= '0;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      sck_q     <= sck_d;
      cs_q      <= cs_d;
      tx_q      <= tx_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      count_q   <= count_d;
    end
  end

  // Receiver: sample index 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_busy_q <= 1'b0;
      rx_cnt_q  <= '0;
      rx_idx_q  <= '0;
      rx_sh_q   <= '0;
      pads_q    <= '0;
    end else if (!rx_busy_q) begin
      if (rx_start) begin
        rx_busy_q <= 1'b1;
        rx_cnt_q  <= 16'(RX_FIRST);
        rx_idx_q  <= '0;
      end
    end else if (rx_cnt_q != 16'd0) begin
      rx_cnt_q <= rx_cnt_q - 16'd1;
    end else begin
      rx_cnt_q <= 16'(BAUD_DIV - 1);
      rx_idx_q <= rx_idx_q + 4'd1;
      if (rx_idx_q == 4'd0 && rx_bit) rx_busy_q <= 1'b0;
      if (rx_idx_q >= 4'd1 && rx_idx_q <= 4'd8) rx_sh_q <= {rx_bit, rx_sh_q[7:1]};
      if (rx_idx_q == 4'd9) begin
        rx_busy_q <= 1'b0;
        if (rx_bit) pads_q <= rx_sh_q[7:1];
      end
    end
  end

  assign uart_tx  = tx_q;
  assign qspi_sck = sck_q;
  assign qspi_dq0 = shift_q[31];
  assign qspi_dq2 = 1'b1;
  assign qspi_dq3 = 1'b1;
  assign qspi_cs0 = cs_q;
  assign qspi_cs1 = 1'b1;
  assign qspi_cs2 = 1'b1;
  assign qspi_cs3 = 1'b1;
  assign pads     = {pads_q, 1'bz};

endmodule

// File: tb/tb_xloader_chip.sv
// Bench for xloader_chip: SPI flash model holding addr[7:0] at each address, UART frame
// monitor, and a table of UART frames injected into the receiver.
module tb_xloader_chip;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reboot_key = 1'b1;
  logic strap = 1'b1;
  logic loop_en = 1'b1;
  logic rx_drv = 1'b1;
  logic miso = 1'b0;
  logic mon_rst = 1'b0;

  wire       uart_rx, uart_tx, qspi_sck;
  wire       qspi_dq0, qspi_dq1, qspi_dq2, qspi_dq3;
  wire       qspi_cs0, qspi_cs1, qspi_cs2, qspi_cs3;
  wire [7:0] pads;

  assign uart_rx  = loop_en ? uart_tx : rx_drv;
  assign qspi_dq1 = miso;
  assign pads     = {7'bz, strap};

  xloader_chip dut (
    .clk        (clk),
    .reset      (reset),
    .reboot_key (reboot_key),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .qspi_sck   (qspi_sck),
    .qspi_dq0   (qspi_dq0),
    .qspi_dq1   (qspi_dq1),
    .qspi_dq2   (qspi_dq2),
    .qspi_dq3   (qspi_dq3),
    .qspi_cs0   (qspi_cs0),
    .qspi_cs1   (qspi_cs1),
    .qspi_cs2   (qspi_cs2),
    .qspi_cs3   (qspi_cs3),
    .pads       (pads)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flash model: mode 0, samples dq0 on sck rise, drives dq1 after sck fall
  int          rises = 0;
  logic [31:0] cmd = '0;
  logic [31:0] last_cmd = '0;
  initial begin
    int n;
    logic [7:0] b;
    forever begin
      @(posedge qspi_sck or negedge qspi_sck or posedge qspi_cs0 or negedge qspi_cs0);
      if (qspi_cs0 !== 1'b0) begin
        rises = 0;
      end else if (rises == 0 && qspi_sck === 1'b0) begin
        cmd      = '0;
        last_cmd = '0;
      end
      if (qspi_cs0 === 1'b0 && qspi_sck === 1'b1) begin
        if (rises < 32) cmd = {cmd[30:0], qspi_dq0};
        rises++;
        if (rises == 32) last_cmd = cmd;
      end else if (qspi_cs0 === 1'b0 && qspi_sck === 1'b0 && rises >= 32) begin
        n    = rises - 32;
        b    = cmd[7:0] + 8'(n / 8);
        miso = b[3'(7 - n % 8)];
      end
    end
  end

  // UART monitor: two samples per bit (one per clock), both must agree
  logic [7:0]  rxq[$];
  int          mon_ph = -1;
  int          mon_err = 0;
  logic [19:0] mon_s = '0;
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_rst) begin
        mon_ph  = -1;
        mon_err = 0;
        rxq.delete();
      end else if (mon_ph < 0) begin
        if (uart_tx === 1'b0) begin
          mon_s[0] = 1'b0;
          mon_ph   = 1;
        end
      end else begin
        mon_s[mon_ph] = uart_tx;
        mon_ph++;
        if (mon_ph == 20) begin
          for (int i = 0; i < 10; i++) if (mon_s[2*i] !== mon_s[2*i+1]) mon_err++;
          if (mon_s[1] !== 1'b0 || mon_s[19] !== 1'b1) mon_err++;
          for (int i = 0; i < 8; i++) b[i] = mon_s[2+2*i];
          rxq.push_back(b);
          mon_ph = -1;
        end
      end
    end
  end

  task automatic pulse_mon_rst();
    mon_rst = 1'b1;
    repeat (2) @(negedge clk);
    mon_rst = 1'b0;
  endtask

  task automatic wait_cs(input logic lvl, input int budget, input string name);
    int t = 0;
    while (qspi_cs0 !== lvl && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(name, 32'(qspi_cs0 === lvl), 32'd1);
  endtask

  task automatic check_boot(input string name);
    wait_cs(1'b0, 20, {name, "_cs_low"});
    wait_cs(1'b1, 3000, {name, "_cs_high"});
    repeat (40) @(negedge clk);
    check({name, "_cmd"}, last_cmd, 32'h0300_0000);
    check({name, "_count"}, 32'(rxq.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < rxq.size()) check($sformatf("%s_byte%0d", name, i), 32'(rxq[i]), 32'(i));
    check({name, "_frame_err"}, 32'(mon_err), 32'd0);
    check({name, "_pads"}, 32'(pads[7:1]), 32'h07);
    repeat (100) @(negedge clk);
    check({name, "_done_idle"}, {29'd0, qspi_cs0, uart_tx, qspi_sck}, 32'b110);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = f[i];
      repeat (2) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [6:0] exp_pads;
  } rx_vec_t;

  rx_vec_t vecs[8];

  initial begin
    int t;
    int bad;
    vecs[0] = '{8'hA5, 1'b1, 7'h52};
    vecs[1] = '{8'h3C, 1'b0, 7'h52};
    vecs[2] = '{8'hFF, 1'b1, 7'h7F};
    vecs[3] = '{8'h80, 1'b0, 7'h7F};
    vecs[4] = '{8'h01, 1'b1, 7'h00};
    vecs[5] = '{8'h80, 1'b1, 7'h40};
    vecs[6] = '{8'h6B, 1'b1, 7'h35};
    vecs[7] = '{8'h00, 1'b0, 7'h35};

    repeat (3) @(negedge clk);
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_sck", 32'(qspi_sck), 32'd0);
    check("rst_dq0", 32'(qspi_dq0), 32'd0);
    check("rst_cs", 32'({qspi_cs3, qspi_cs2, qspi_cs1, qspi_cs0}), 32'hF);
    check("rst_pads", 32'(pads[7:1]), 32'd0);
    check("rst_wp_hold", 32'({qspi_dq3, qspi_dq2}), 32'h3);

    pulse_mon_rst();
    reset = 1'b0;
    check_boot("boot");
    check("boot_cs123", 32'({qspi_cs3, qspi_cs2, qspi_cs1}), 32'h7);

    // Reboot from DONE, then abort it again in the middle of byte 5
    pulse_mon_rst();
    reboot_key = 1'b0;
    repeat (4) @(negedge clk);
    reboot_key = 1'b1;
    wait_cs(1'b0, 20, "reboot_start");
    t = 0;
    while (rxq.size() < 5 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("reboot_five_bytes", 32'(rxq.size()), 32'd5);
    t = 0;
    while (uart_tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("byte5_start", 32'(uart_tx), 32'd0);
    repeat (3) @(negedge clk);
    reboot_key = 1'b0;
    t = 0;
    while (qspi_cs0 !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("abort_cs", 32'(qspi_cs0), 32'd1);
    check("abort_tx", 32'(uart_tx), 32'd1);
    @(negedge clk);
    check("abort_cs_hold", 32'(qspi_cs0), 32'd1);
    reboot_key = 1'b1;
    pulse_mon_rst();
    check_boot("reboot");

    // Async reset while the command is shifting with sck high
    pulse_mon_rst();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    t = 0;
    while (!(rises >= 10 && qspi_sck === 1'b1) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("midcmd_reached", 32'(qspi_sck === 1'b1 && qspi_cs0 === 1'b0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midcmd_rst_sck", 32'(qspi_sck), 32'd0);
    check("midcmd_rst_cs", 32'(qspi_cs0), 32'd1);
    repeat (3) @(negedge clk);
    pulse_mon_rst();
    reset = 1'b0;
    check_boot("rst_midcmd");

    // Boot strap low: no flash access and no UART traffic
    strap = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (qspi_cs0 !== 1'b1 || uart_tx !== 1'b1 || qspi_sck !== 1'b0) bad++;
    end
    check("strap0_quiet", 32'(bad), 32'd0);
    check("strap0_pads", 32'(pads[7:1]), 32'd0);

    loop_en = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      check($sformatf("rx_vec%0d", i), 32'(pads[7:1]), 32'(vecs[i].exp_pads));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
